// File: rtl/imm_gen_pipe.sv
// Registered immediate extender between decode and ID/EX, with a prefix
// mechanism that supplies the high byte of a full immediate for the next instruction.
module imm_gen_pipe #(
  parameter int DATA_W = 16,
  parameter int PFX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  input  logic [2:0]        imd_choice,
  input  logic              shft,
  input  logic              is_prefix,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_prefixed,
  output logic              out_err,
  output logic              pfx_pending
);

  typedef enum logic {IDLE, PFX} state_t;

  state_t               state, state_nxt;
  logic [PFX_W-1:0]     pfx_reg;
  logic                 accept;
  logic                 prefixed_p0;
  logic                 err_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic                 unused_hi;

  function automatic logic signed [DATA_W-1:0] ext_normal(input logic [11:0] instr,
                                                          input logic [2:0]  mode);
    logic signed [DATA_W-1:0] r;
    case (mode)
      3'b000:  r = DATA_W'($signed(instr[8:0])) << 1;
      3'b001:  r = DATA_W'($signed(instr[3:0]));
      3'b010:  r = DATA_W'($signed(instr[7:0]));
      3'b011:  r = $signed(DATA_W'(instr[7:0]));
      3'b100:  r = $signed(DATA_W'({instr[7:0], 8'h00}));
      3'b101:  r = DATA_W'($signed(instr[11:0])) << 1;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] ext_prefixed(input logic [PFX_W-1:0] pfx,
                                                            input logic [7:0]       lo);
    return DATA_W'($signed({pfx, lo}));
  endfunction

  function automatic logic signed [DATA_W-1:0] shift_opt(input logic signed [DATA_W-1:0] x,
                                                         input logic                     en);
    return en ? (x << 1) : x;
  endfunction

  assign accept    = in_valid & ~stall & ~flush;
  assign unused_hi = ^in_instr[15:12];

  // Stage p0: combinational extension of the presented instruction
  always_comb begin
    prefixed_p0 = (state == PFX);
    err_p0      = ~prefixed_p0 & imd_choice[2] & imd_choice[1];
    imm_p0      = shift_opt(prefixed_p0 ? ext_prefixed(pfx_reg, in_instr[7:0])
                                        : ext_normal(in_instr[11:0], imd_choice),
                            shft);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)       state_nxt = IDLE;
    else if (accept) state_nxt = is_prefix ? PFX : IDLE;
  end

  always_comb begin
    pfx_pending = (state == PFX);
    in_ready    = ~stall;
  end

  // Stage p0 -> output register; flush wins over stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_prefixed <= 1'b0;
      out_err      <= 1'b0;
      pfx_reg      <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_prefixed <= 1'b0;
      out_err      <= 1'b0;
      pfx_reg      <= '0;
    end else if (!stall) begin
      out_valid <= accept & ~is_prefix;
      if (accept) begin
        if (is_prefix) begin
          pfx_reg <= in_instr[PFX_W-1:0];
        end else begin
          out_imm      <= imm_p0;
          out_prefixed <= prefixed_p0;
          out_err      <= err_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 16-bit instance plus a 20-bit instance
// sharing the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [2:0]  imd_choice;
  logic        shft;
  logic        is_prefix;
  logic        stall;
  logic        flush;

  logic        in_ready, out_valid, out_prefixed, out_err, pfx_pending;
  logic [15:0] out_imm;
  logic        in_ready20, out_valid20, out_prefixed20, out_err20, pfx_pending20;
  logic [19:0] out_imm20;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_W(16), .PFX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .imd_choice(imd_choice), .shft(shft), .is_prefix(is_prefix),
    .stall(stall), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
    .out_imm(out_imm), .out_prefixed(out_prefixed), .out_err(out_err),
    .pfx_pending(pfx_pending)
  );

  imm_gen_pipe #(.DATA_W(20), .PFX_W(8)) dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .imd_choice(imd_choice), .shft(shft), .is_prefix(is_prefix),
    .stall(stall), .flush(flush), .in_ready(in_ready20), .out_valid(out_valid20),
    .out_imm(out_imm20), .out_prefixed(out_prefixed20), .out_err(out_err20),
    .pfx_pending(pfx_pending20)
  );

  // Present one instruction for one cycle; returns #1 after the accepting edge.
  task automatic drive(input logic [15:0] instr, input logic [2:0] mode,
                       input logic sh, input logic pfx);
    in_valid = 1'b1; in_instr = instr; imd_choice = mode; shft = sh; is_prefix = pfx;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; is_prefix = 1'b0; shft = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; imd_choice = '0;
    shft = 1'b0; is_prefix = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (out_imm !== 16'h0) begin miscompares++; $display("FAIL reset_imm got %h want 0000", out_imm); end
    vectors++; if (out_prefixed !== 1'b0) begin miscompares++; $display("FAIL reset_prefixed got %b want 0", out_prefixed); end
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", out_err); end
    vectors++; if (pfx_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending got %b want 0", pfx_pending); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    logic [15:0] instr_t [6] = '{16'h01FF, 16'h0008, 16'h0080, 16'h00F0, 16'h00A5, 16'h0800};
    logic [2:0]  mode_t  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    logic [15:0] exp_t   [6] = '{16'hFFFE, 16'hFFF8, 16'hFF80, 16'h00F0, 16'hA500, 16'hF000};
    for (int i = 0; i < 6; i++) begin
      drive(instr_t[i], mode_t[i], 1'b0, 1'b0);
      vectors++; if (out_imm !== exp_t[i] || out_valid !== 1'b1 || out_err !== 1'b0) begin
        miscompares++;
        $display("FAIL mode%0d got imm=%h v=%b e=%b want imm=%h v=1 e=0", i, out_imm, out_valid, out_err, exp_t[i]);
      end
    end
    idle();
    vectors++; if (out_valid !== 1'b0 || out_imm !== 16'hF000) begin
      miscompares++; $display("FAIL idle_hold got v=%b imm=%h want v=0 imm=f000", out_valid, out_imm);
    end
  endtask

  task automatic test_shft();
    drive(16'h01FF, 3'b000, 1'b1, 1'b0);
    vectors++; if (out_imm !== 16'hFFFC) begin miscompares++; $display("FAIL shft_m0 got %h want fffc", out_imm); end
    drive(16'h0080, 3'b010, 1'b1, 1'b0);
    vectors++; if (out_imm !== 16'hFF00) begin miscompares++; $display("FAIL shft_m2 got %h want ff00", out_imm); end
    idle();
  endtask

  task automatic test_prefix();
    drive(16'h0012, 3'b000, 1'b0, 1'b1);
    vectors++; if (out_valid !== 1'b0 || pfx_pending !== 1'b1) begin
      miscompares++; $display("FAIL pfx_first got v=%b p=%b want v=0 p=1", out_valid, pfx_pending);
    end
    drive(16'h0034, 3'b010, 1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b1 || out_imm !== 16'h1234 || out_prefixed !== 1'b1 || pfx_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL pfx_second got v=%b imm=%h pf=%b p=%b want v=1 imm=1234 pf=1 p=0", out_valid, out_imm, out_prefixed, pfx_pending);
    end
    drive(16'h00AB, 3'b000, 1'b0, 1'b1);
    drive(16'h00CD, 3'b011, 1'b0, 1'b0);
    vectors++; if (out_imm20 !== 20'hFABCD || out_prefixed20 !== 1'b1) begin
      miscompares++; $display("FAIL pfx_w20 got %h pf=%b want fabcd pf=1", out_imm20, out_prefixed20);
    end
    vectors++; if (out_imm !== 16'hABCD) begin miscompares++; $display("FAIL pfx_w16 got %h want abcd", out_imm); end
    idle();
  endtask

  task automatic test_overwrite();
    drive(16'h0011, 3'b000, 1'b0, 1'b1);
    drive(16'h0022, 3'b000, 1'b0, 1'b1);
    vectors++; if (pfx_pending !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL ovw_pending got p=%b v=%b want p=1 v=0", pfx_pending, out_valid);
    end
    drive(16'h0033, 3'b010, 1'b0, 1'b0);
    vectors++; if (out_imm !== 16'h2233 || out_prefixed !== 1'b1) begin
      miscompares++; $display("FAIL ovw_result got %h pf=%b want 2233 pf=1", out_imm, out_prefixed);
    end
    idle();
  endtask

  task automatic test_flush();
    drive(16'h0011, 3'b000, 1'b0, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++; if (pfx_pending !== 1'b0 || out_valid !== 1'b0 || out_imm !== 16'h0) begin
      miscompares++; $display("FAIL flush_clear got p=%b v=%b imm=%h want p=0 v=0 imm=0000", pfx_pending, out_valid, out_imm);
    end
    drive(16'h0033, 3'b010, 1'b0, 1'b0);
    vectors++; if (out_imm !== 16'h0033 || out_prefixed !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL flush_next got %h pf=%b v=%b want 0033 pf=0 v=1", out_imm, out_prefixed, out_valid);
    end
  endtask

  task automatic test_stall();
    drive(16'h00A5, 3'b100, 1'b0, 1'b0);
    stall = 1'b1; in_valid = 1'b1; in_instr = 16'h0077; imd_choice = 3'b000; is_prefix = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 16'hA500 || pfx_pending !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d got r=%b v=%b imm=%h p=%b want r=0 v=1 imm=a500 p=0", i, in_ready, out_valid, out_imm, pfx_pending);
      end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (pfx_pending !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL stall_release got p=%b v=%b r=%b want p=1 v=0 r=1", pfx_pending, out_valid, in_ready);
    end
    stall = 1'b1; in_valid = 1'b1; in_instr = 16'h0011; imd_choice = 3'b010; is_prefix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (pfx_pending !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall_pfx_hold got p=%b v=%b want p=1 v=0", pfx_pending, out_valid);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (out_imm !== 16'h7711 || out_prefixed !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL stall_resume got %h pf=%b v=%b want 7711 pf=1 v=1", out_imm, out_prefixed, out_valid);
    end
  endtask

  task automatic test_stall_flush();
    drive(16'h0044, 3'b000, 1'b0, 1'b1);
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 16'h0055; is_prefix = 1'b0; imd_choice = 3'b010;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0 || pfx_pending !== 1'b0 || out_imm !== 16'h0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_flush got v=%b p=%b imm=%h r=%b want v=0 p=0 imm=0000 r=0", out_valid, pfx_pending, out_imm, in_ready);
    end
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    idle();
  endtask

  task automatic test_reserved();
    drive(16'h1234, 3'b110, 1'b0, 1'b0);
    vectors++; if (out_imm !== 16'h0 || out_err !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL rsv110 got imm=%h e=%b v=%b want 0000 e=1 v=1", out_imm, out_err, out_valid);
    end
    drive(16'hFFFF, 3'b111, 1'b1, 1'b0);
    vectors++; if (out_imm !== 16'h0 || out_err !== 1'b1) begin
      miscompares++; $display("FAIL rsv111 got imm=%h e=%b want 0000 e=1", out_imm, out_err);
    end
    drive(16'h00F0, 3'b011, 1'b0, 1'b0);
    vectors++; if (out_err !== 1'b0 || out_imm !== 16'h00F0) begin
      miscompares++; $display("FAIL rsv_clear got imm=%h e=%b want 00f0 e=0", out_imm, out_err);
    end
    drive(16'h0001, 3'b000, 1'b0, 1'b1);
    drive(16'h0002, 3'b110, 1'b0, 1'b0);
    vectors++; if (out_imm !== 16'h0102 || out_err !== 1'b0 || out_prefixed !== 1'b1) begin
      miscompares++; $display("FAIL rsv_prefixed got imm=%h e=%b pf=%b want 0102 e=0 pf=1", out_imm, out_err, out_prefixed);
    end
    idle();
  endtask

  task automatic test_reset_mid_pfx();
    drive(16'h0055, 3'b000, 1'b0, 1'b1);
    vectors++; if (pfx_pending !== 1'b1) begin miscompares++; $display("FAIL rst_pre got p=%b want 1", pfx_pending); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (pfx_pending !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_async got p=%b v=%b want p=0 v=0", pfx_pending, out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive(16'h0034, 3'b010, 1'b0, 1'b0);
    vectors++; if (out_imm !== 16'h0034 || out_prefixed !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_next got %h pf=%b v=%b want 0034 pf=0 v=1", out_imm, out_prefixed, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_shft();
    test_prefix();
    test_overwrite();
    test_flush();
    test_stall();
    test_stall_flush();
    test_reserved();
    test_reset_mid_pfx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
